// File: rtl/tinyqv_prefetch_buffer.sv
// tinyqv_prefetch_buffer: instruction prefetch queue between memory and decoder.
// Fetches sequential halfwords, buffers up to DEPTH of them, and presents one
// aligned 16-bit or 32-bit instruction with its PC. A branch flushes the queue
// and restarts fetching from the target.
// Optional feature macro: TINYQV_PREFETCH_BYPASS_EN (same-cycle fetch_data -> instr path).
module tinyqv_prefetch_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [22:0] RESET_ADDR = 23'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        branch,
    input  logic [22:0] branch_addr,
    output logic        fetch_req,
    output logic [22:0] fetch_addr,
    output logic        fetch_restart,
    input  logic        fetch_data_valid,
    input  logic [15:0] fetch_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        instr_compressed,
    output logic [22:0] instr_pc,
    input  logic        instr_take
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [15:0]      h0;
    logic [15:0]      h1;
    logic [15:0]      head_lo;
    logic [15:0]      head_hi;
    logic             head_valid;
    logic             push_ok;
    logic             take_ok;
    logic             consume_direct;
    logic             write_en;
    logic [CNT_W-1:0] pop_size;
    logic [CNT_W-1:0] pop_amt;

    // Head decode, fetch request and push/pop qualification
    always_comb begin
        h0             = mem[rd_ptr];
        h1             = mem[rd_ptr + PTR_W'(1)];
        head_lo        = h0;
        head_hi        = h1;
        consume_direct = 1'b0;
        push_ok        = fetch_data_valid && !branch && (count != CNT_W'(DEPTH));
        head_valid     = ((count >= CNT_W'(1)) && (h0[1:0] != 2'b11)) || (count >= CNT_W'(2));
        fetch_req      = rstn && !branch && ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
`ifdef TINYQV_PREFETCH_BYPASS_EN
        if (push_ok && (count == CNT_W'(0)) && (fetch_data[1:0] != 2'b11)) begin
            head_lo    = fetch_data;
            head_valid = 1'b1;
        end
        if (push_ok && (count == CNT_W'(1)) && (h0[1:0] == 2'b11)) begin
            head_hi    = fetch_data;
            head_valid = 1'b1;
        end
`endif
        instr_compressed = (head_lo[1:0] != 2'b11);
        instr            = instr_compressed ? {16'h0, head_lo} : {head_hi, head_lo};
        instr_valid      = rstn && head_valid;
        take_ok          = instr_take && instr_valid && !branch;
        pop_size         = instr_compressed ? CNT_W'(1) : CNT_W'(2);
`ifdef TINYQV_PREFETCH_BYPASS_EN
        // A bypassed compressed halfword taken immediately never enters the queue
        consume_direct   = take_ok && (count == CNT_W'(0));
`endif
        write_en         = push_ok && !consume_direct;
        pop_amt          = (take_ok && !consume_direct) ? pop_size : CNT_W'(0);
    end

    // Queue storage; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (rstn && !branch && write_en) begin
            mem[wr_ptr] <= fetch_data;
        end
    end

    // Pointers, occupancy, fetch/PC tracking and restart pulse
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_addr    <= RESET_ADDR;
            instr_pc      <= RESET_ADDR;
            fetch_restart <= 1'b0;
        end else if (branch) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fetch_addr    <= branch_addr;
            instr_pc      <= branch_addr;
            fetch_restart <= 1'b1;
        end else begin
            fetch_restart <= 1'b0;
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                fetch_addr <= fetch_addr + 23'(1);
            end
            if (take_ok) begin
                instr_pc <= instr_pc + 23'(pop_size);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_amt);
            count  <= count + CNT_W'(write_en) - pop_amt;
        end
    end

endmodule

// File: tb/tb_tinyqv_prefetch_buffer.sv
// Self-checking bench for tinyqv_prefetch_buffer: halfword stream assembled by a
// small model into expected instructions, popped and compared on each take.
module tb_tinyqv_prefetch_buffer;

    localparam logic [22:0] RA = 23'h40;

    logic        clk;
    logic        rstn;
    logic        branch;
    logic [22:0] branch_addr;
    logic        fetch_req;
    logic [22:0] fetch_addr;
    logic        fetch_restart;
    logic        fetch_data_valid;
    logic [15:0] fetch_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_compressed;
    logic [22:0] instr_pc;
    logic        instr_take;

    tinyqv_prefetch_buffer #(.DEPTH(4), .RESET_ADDR(RA)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .branch           (branch),
        .branch_addr      (branch_addr),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_restart    (fetch_restart),
        .fetch_data_valid (fetch_data_valid),
        .fetch_data       (fetch_data),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_compressed (instr_compressed),
        .instr_pc         (instr_pc),
        .instr_take       (instr_take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] pc;
        logic [31:0] ins;
        logic        c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        have_lo;
    logic [15:0] lo;
    logic [22:0] asm_pc;
    logic [22:0] efa;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assemble the fetched halfword stream into expected instructions
    task automatic model_push(input logic [15:0] h);
        exp_t e;
        if (have_lo) begin
            e.pc = asm_pc; e.ins = {h, lo}; e.c = 1'b0;
            exp_q.push_back(e);
            asm_pc  = asm_pc + 23'd2;
            have_lo = 1'b0;
        end else if (h[1:0] != 2'b11) begin
            e.pc = asm_pc; e.ins = {16'h0, h}; e.c = 1'b1;
            exp_q.push_back(e);
            asm_pc = asm_pc + 23'd1;
        end else begin
            lo      = h;
            have_lo = 1'b1;
        end
    endtask

    // One clock: optionally return a halfword and/or take the head instruction
    task automatic cycle(input bit push, input logic [15:0] h, input bit take);
        exp_t e;
        if (take) begin
            check_val("take_valid", instr_valid, 1);
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_val("instr", instr, e.ins);
                check_val("instr_pc", instr_pc, e.pc);
                check_val("compressed", instr_compressed, e.c);
            end
        end
        if (push) check_val("req_before_push", fetch_req, 1);
        fetch_data_valid = push;
        fetch_data       = h;
        instr_take       = take;
        if (push) begin
            model_push(h);
            efa = efa + 23'd1;
        end
        tick();
        fetch_data_valid = 1'b0;
        instr_take       = 1'b0;
        check_val("fetch_addr", fetch_addr, efa);
    endtask

    initial begin
        rstn = 1'b0; branch = 1'b0; branch_addr = '0;
        fetch_data_valid = 1'b0; fetch_data = '0; instr_take = 1'b0;
        have_lo = 1'b0; lo = '0; asm_pc = RA; efa = RA;

        // Reset
        tick(); tick();
        check_val("rst_req", fetch_req, 0);
        check_val("rst_valid", instr_valid, 0);
        rstn = 1'b1;
        #1;
        check_val("rst_fetch_addr", fetch_addr, RA);
        check_val("rst_pc", instr_pc, RA);
        check_val("rst_restart", fetch_restart, 0);
        check_val("rst_req_rel", fetch_req, 1);
        check_val("rst_valid_rel", instr_valid, 0);
        tick();
        check_val("idle_valid", instr_valid, 0);

        // Compressed instruction
        cycle(1, 16'h4501, 0);
        cycle(0, 16'h0, 1);
        check_val("t2_pc", instr_pc, 23'h41);

        // 32-bit instruction valid only after second halfword
        cycle(1, 16'h0513, 0);
        check_val("t3_partial", instr_valid, 0);
        cycle(1, 16'h0000, 0);
        cycle(0, 16'h0, 1);
        check_val("t3_pc", instr_pc, 23'h43);

        // Fill without taking
        cycle(1, 16'h0001, 0);
        check_val("t4_req1", fetch_req, 1);
        cycle(1, 16'h0005, 0);
        check_val("t4_req2", fetch_req, 1);
        cycle(1, 16'h0009, 0);
        check_val("t4_req_fall", fetch_req, 0);
        fetch_data_valid = 1'b1; fetch_data = 16'h000D;
        model_push(16'h000D); efa = efa + 23'd1;
        tick();
        fetch_data_valid = 1'b0;
        check_val("t4_req_full", fetch_req, 0);
        check_val("t4_fa_extra", fetch_addr, efa);
        fetch_data_valid = 1'b1; fetch_data = 16'hFFFF;
        tick();
        fetch_data_valid = 1'b0;
        check_val("t4_fa_overflow", fetch_addr, efa);
        check_val("t4_pc_hold", instr_pc, 23'h43);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1);
        check_val("t4_drained", instr_valid, 0);

        // Branch with simultaneous data and take
        cycle(1, 16'h0011, 0);
        cycle(1, 16'h0013, 0);
        cycle(1, 16'h0015, 0);
        branch = 1'b1; branch_addr = 23'h1235;
        fetch_data_valid = 1'b1; fetch_data = 16'hAAAA; instr_take = 1'b1;
        #1;
        check_val("br_req_low", fetch_req, 0);
        tick();
        branch = 1'b0; fetch_data_valid = 1'b0; instr_take = 1'b0;
        exp_q.delete(); have_lo = 1'b0; asm_pc = 23'h1235; efa = 23'h1235;
        #1;
        check_val("br_restart", fetch_restart, 1);
        check_val("br_valid", instr_valid, 0);
        check_val("br_fetch_addr", fetch_addr, 23'h1235);
        check_val("br_pc", instr_pc, 23'h1235);
        check_val("br_req_back", fetch_req, 1);
        tick();
        check_val("br_restart_end", fetch_restart, 0);
        cycle(1, 16'h4505, 0);
        cycle(0, 16'h0, 1);

        // Simultaneous push and take at count 2, wrapping pointers
        cycle(1, 16'h0001, 0);
        cycle(1, 16'h0005, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'h0021 + 16'(4 * i), 1);
            check_val("t6_req", fetch_req, 1);
            check_val("t6_valid", instr_valid, 1);
        end
        cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 1);
        check_val("t6_empty", instr_valid, 0);

`ifdef TINYQV_PREFETCH_BYPASS_EN
        // Same-cycle presentation at count 0, consumed without being queued
        fetch_data_valid = 1'b1; fetch_data = 16'h4509;
        #1;
        check_val("byp_valid", instr_valid, 1);
        check_val("byp_instr", instr, 32'h00004509);
        check_val("byp_pc", instr_pc, asm_pc);
        instr_take = 1'b1;
        tick();
        fetch_data_valid = 1'b0; instr_take = 1'b0;
        asm_pc = asm_pc + 23'd1; efa = efa + 23'd1;
        check_val("byp_pc_adv", instr_pc, asm_pc);
        check_val("byp_not_queued", instr_valid, 0);
        check_val("byp_fa", fetch_addr, efa);
`else
        // Without bypass the halfword is visible only after it is registered
        fetch_data_valid = 1'b1; fetch_data = 16'h4509;
        #1;
        check_val("nobyp_valid", instr_valid, 0);
        tick();
        fetch_data_valid = 1'b0;
        model_push(16'h4509); efa = efa + 23'd1;
        cycle(0, 16'h0, 1);
`endif
        check_val("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
